// File: rtl/avl_mem_responder.sv
// Avalon-MM DDR3-controller stand-in: byte-masked 64-bit on-chip memory with
// fixed-latency in-order read returns, outstanding-read throttling and a sticky error flag.
module avl_mem_responder #(
  parameter int addr_bits       = 10,
  parameter int read_latency    = 4,
  parameter int max_outstanding = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        avl_ready,
  input  logic        avl_burstbegin,
  input  logic [23:0] avl_addr,
  output logic        avl_rdata_valid,
  output logic [63:0] avl_rdata,
  input  logic [63:0] avl_wdata,
  input  logic [7:0]  avl_be,
  input  logic        avl_read_req,
  input  logic        avl_write_req,
  input  logic [6:0]  avl_size,
  output logic        protocol_error
);

  localparam int depth    = 1 << addr_bits;
  localparam int cnt_bits = $clog2(max_outstanding + 1);
  localparam logic [cnt_bits-1:0] cnt_max = cnt_bits'(max_outstanding);

  logic                 accept;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 bad_req;
  logic [addr_bits-1:0] idx;
  logic [63:0]          mem_q;
  logic [63:0]          pipe_out;
  logic [read_latency:1] vld_reg;
  logic [cnt_bits-1:0]  cnt_reg;
  logic [cnt_bits-1:0]  cnt_next;
  logic                 ready_reg;
  logic                 ready_next;
  logic                 perr_reg;
  logic                 unused_inputs;

  if (addr_bits < 1 || addr_bits > 24) begin : g_bad_addr_bits
    $error("avl_mem_responder: addr_bits must be 1..24");
  end
  if (read_latency < 1 || read_latency > 16) begin : g_bad_latency
    $error("avl_mem_responder: read_latency must be 1..16");
  end
  if (max_outstanding < 1 || max_outstanding > 255) begin : g_bad_outstanding
    $error("avl_mem_responder: max_outstanding must be 1..255");
  end

  // Single-beat only: burstbegin carries no information, upper address bits alias.
  assign unused_inputs = avl_burstbegin ^ (|(avl_addr >> addr_bits));

  assign idx     = avl_addr[addr_bits-1:0];
  assign accept  = ready_reg && (avl_read_req || avl_write_req);
  assign wr_acc  = accept && avl_write_req;
  assign rd_acc  = accept && avl_read_req && !avl_write_req;
  assign bad_req = (avl_read_req && avl_write_req) || (avl_size != 7'd1);

  // One RAM per byte lane keeps byte-enable writes a plain per-lane write enable;
  // the lane output register doubles as read pipeline stage 1.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [depth];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (wr_acc && avl_be[gi]) begin
          lane_mem[idx] <= avl_wdata[8*gi +: 8];
        end
        if (rd_acc) begin
          lane_q_reg <= lane_mem[idx];
        end
      end

      assign mem_q[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

  generate
    if (read_latency == 1) begin : g_lat1
      assign pipe_out = mem_q;
    end else begin : g_pipe
      logic [63:0] dat_reg [2:read_latency];

      always_ff @(posedge clk) begin
        dat_reg[2] <= mem_q;
        for (int i = 3; i <= read_latency; i++) begin
          dat_reg[i] <= dat_reg[i-1];
        end
      end

      assign pipe_out = dat_reg[read_latency];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg <= '0;
    end else begin
      vld_reg[1] <= rd_acc;
      for (int i = 2; i <= read_latency; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (rd_acc && !vld_reg[read_latency]) begin
      cnt_next = cnt_reg + cnt_bits'(1);
    end else if (!rd_acc && vld_reg[read_latency]) begin
      cnt_next = cnt_reg - cnt_bits'(1);
    end
  end

  assign ready_next = !stall && (cnt_next < cnt_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      if (accept && bad_req) begin
        perr_reg <= 1'b1;
      end
    end
  end

  assign avl_ready       = ready_reg;
  assign avl_rdata_valid = vld_reg[read_latency];
  assign avl_rdata       = vld_reg[read_latency] ? pipe_out : 64'd0;
  assign protocol_error  = perr_reg;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Scoreboarded bench for avl_mem_responder: default instance plus a
// max_outstanding=2 instance for the throttling scenario.
module tb_avl_mem_responder;

  localparam int lat = 4;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [23:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  be_in = '0;
  logic [6:0]  size = 7'd1;

  logic        ready0, valid0, perr0;
  logic        ready1, valid1, perr1;
  logic [63:0] rdata0, rdata1;
  logic        rd0, wr0, rd1, wr1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int valid_seen0 = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] model0 [1024];
  logic [63:0] model1 [1024];

  assign rd0 = rd && !sel;
  assign wr0 = wr && !sel;
  assign rd1 = rd && sel;
  assign wr1 = wr && sel;

  avl_mem_responder dut (
    .clk(clk), .reset(reset), .stall(stall), .avl_ready(ready0),
    .avl_burstbegin(rd0 | wr0), .avl_addr(addr), .avl_rdata_valid(valid0),
    .avl_rdata(rdata0), .avl_wdata(wdata), .avl_be(be_in),
    .avl_read_req(rd0), .avl_write_req(wr0), .avl_size(size),
    .protocol_error(perr0)
  );

  avl_mem_responder #(.max_outstanding(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .avl_ready(ready1),
    .avl_burstbegin(rd1 | wr1), .avl_addr(addr), .avl_rdata_valid(valid1),
    .avl_rdata(rdata1), .avl_wdata(wdata), .avl_be(be_in),
    .avl_read_req(rd1), .avl_write_req(wr1), .avl_size(size),
    .protocol_error(perr1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every valid beat must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (valid0) begin
      valid_seen0++;
      if (q0.size() == 0) begin
        check("rsp0_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        $display("rsp inst 0 cyc %0d data %h", cyc, rdata0);
        check("rsp0_data", rdata0, e.data);
        check("rsp0_cycle", cyc, e.cyc);
      end
    end else begin
      check("rsp0_idle_zero", rdata0, 64'd0);
    end
    if (valid1) begin
      if (q1.size() == 0) begin
        check("rsp1_unexpected", 1, 0);
      end else begin
        e = q1.pop_front();
        $display("rsp inst 1 cyc %0d data %h", cyc, rdata1);
        check("rsp1_data", rdata1, e.data);
        check("rsp1_cycle", cyc, e.cyc);
      end
    end else begin
      check("rsp1_idle_zero", rdata1, 64'd0);
    end
  end

  // Call right after a rising edge; returns one cycle after acceptance.
  task automatic do_req(input logic r, input logic w, input logic [23:0] a,
                        input logic [63:0] d, input logic [7:0] be, input logic [6:0] sz,
                        input bit track, output int acc);
    int waited;
    logic [9:0] ix;
    exp_t e;
    waited = 0;
    acc = -1;
    ix = a[9:0];
    rd = r; wr = w; addr = a; wdata = d; be_in = be; size = sz;
    while (acc < 0 && waited < 100) begin
      @(negedge clk);
      if (sel ? ready1 : ready0) acc = cyc;
      else waited++;
    end
    if (acc < 0) begin
      check("req_accept_timeout", 0, 1);
    end else begin
      if (w) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) begin
            if (sel) model1[ix][8*i +: 8] = d[8*i +: 8];
            else     model0[ix][8*i +: 8] = d[8*i +: 8];
          end
        end
      end else if (r && track) begin
        e.data = sel ? model1[ix] : model0[ix];
        e.cyc  = acc + lat;
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
      end
      $display("req inst %0d cyc %0d rd %0b wr %0b addr %h data %h be %h size %0d",
               sel, acc, r, w, a, d, be, sz);
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    size = 7'd1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
    tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", ready0, 0);
      check("rst_valid", valid0, 0);
      check("rst_rdata", rdata0, 64'd0);
      check("rst_perr", perr0, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("release_ready_c1", ready0, 0);
    @(negedge clk);
    check("release_ready_c2", ready0, 1);
    check("release_ready1_c2", ready1, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_a, acc_b, acc_c, s_cyc, seen;
    do_reset();

    // Latency and data.
    do_req(0, 1, 24'd5, 64'h1122334455667788, 8'hFF, 7'd1, 1, acc);
    do_req(1, 0, 24'd5, 64'd0, 8'h00, 7'd1, 1, acc);
    drain();

    // Byte masking.
    do_req(0, 1, 24'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 7'd1, 1, acc);
    do_req(0, 1, 24'd9, 64'd0, 8'h0F, 7'd1, 1, acc);
    do_req(1, 0, 24'd9, 64'd0, 8'h00, 7'd1, 1, acc);
    drain();

    // Aliasing, back-to-back reads, no-op write.
    do_req(0, 1, 24'h400, 64'hA5, 8'hFF, 7'd1, 1, acc);
    do_req(0, 1, 24'd1, 64'h0101_0101_DEAD_BEEF, 8'hFF, 7'd1, 1, acc);
    do_req(0, 1, 24'd2, 64'h0202_0202_CAFE_F00D, 8'hFF, 7'd1, 1, acc);
    do_req(0, 1, 24'd2, 64'h1234_5678_9ABC_DEF0, 8'h00, 7'd1, 1, acc);
    do_req(1, 0, 24'd0, 64'd0, 8'h00, 7'd1, 1, acc_a);
    do_req(1, 0, 24'd1, 64'd0, 8'h00, 7'd1, 1, acc_b);
    do_req(1, 0, 24'd2, 64'd0, 8'h00, 7'd1, 1, acc_c);
    check("b2b_accept_consecutive", acc_c - acc_a, 2);
    drain();

    // Outstanding limit on the max_outstanding=2 instance.
    sel = 1'b1;
    do_req(0, 1, 24'd3, 64'h3333_0000_3333_0000, 8'hFF, 7'd1, 1, acc);
    do_req(0, 1, 24'd4, 64'h4444_0000_4444_0000, 8'hFF, 7'd1, 1, acc);
    do_req(1, 0, 24'd3, 64'd0, 8'h00, 7'd1, 1, acc_a);
    do_req(1, 0, 24'd4, 64'd0, 8'h00, 7'd1, 1, acc_b);
    fork
      do_req(1, 0, 24'd3, 64'd0, 8'h00, 7'd1, 1, acc_c);
      begin
        @(negedge clk);
        check("limit_ready_low", ready1, 0);
      end
    join
    check("limit_second_accept", acc_b, acc_a + 1);
    check("limit_third_accept", acc_c, acc_a + lat + 1);
    drain();
    sel = 1'b0;

    // Stall holds a write until it clears.
    do_req(0, 1, 24'd20, 64'h2020_2020_2020_2020, 8'hFF, 7'd1, 1, acc);
    stall = 1'b1;
    tick();
    s_cyc = 0;
    fork
      do_req(0, 1, 24'd20, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 7'd1, 1, acc);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready_low", ready0, 0);
        end
        stall = 1'b0;
        s_cyc = cyc;
      end
    join
    check("stall_write_accept_cycle", acc, s_cyc + 1);
    do_req(1, 0, 24'd20, 64'd0, 8'h00, 7'd1, 1, acc);
    drain();

    // Read and write together: write wins, no response, sticky error.
    check("perr_clear_before", perr0, 0);
    do_req(1, 1, 24'd30, 64'h3030_ABAB_3030_ABAB, 8'hFF, 7'd1, 1, acc);
    @(negedge clk);
    check("perr_rdwr", perr0, 1);
    tick();
    do_req(1, 0, 24'd30, 64'd0, 8'h00, 7'd1, 1, acc);
    drain();
    check("perr_sticky", perr0, 1);

    // Fresh reset, then an unsupported burst size.
    do_reset();
    do_req(1, 0, 24'd30, 64'd0, 8'h00, 7'd2, 1, acc);
    drain();
    check("perr_size", perr0, 1);

    // Reset with reads in flight: none may return; memory survives.
    do_reset();
    do_req(0, 1, 24'd40, 64'h4040_4040_5A5A_5A5A, 8'hFF, 7'd1, 1, acc);
    drain();
    seen = valid_seen0;
    do_req(1, 0, 24'd5, 64'd0, 8'h00, 7'd1, 0, acc);
    do_req(1, 0, 24'd9, 64'd0, 8'h00, 7'd1, 0, acc);
    do_req(1, 0, 24'd40, 64'd0, 8'h00, 7'd1, 0, acc);
    do_reset();
    repeat (8) @(negedge clk);
    check("inflight_discarded", valid_seen0, seen);
    tick();
    do_req(1, 0, 24'd40, 64'd0, 8'h00, 7'd1, 1, acc);
    do_req(1, 0, 24'd5, 64'd0, 8'h00, 7'd1, 1, acc);
    drain();

    repeat (4) @(negedge clk);
    check("final_queue_empty", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
